// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Round-robin arbiter for the single write port of the 2R1W register file.
//   NUM_REQ writeback sources compete for the port. A sweep engine can be
//   started to zero registers 1..2^ADDRESS_WIDTH-1, one per cycle.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is combinational,
//                         one-hot or zero)
//   req_addr, req_data    packed per-requester address / data
//   init_start            one-cycle pulse that starts the zeroing sweep
//   init_busy             high in every sweep cycle
//   waddr, wdata, wena    registered regfile write port
//   wr_src                requester index behind the current write (debug)
//   x0_drops              saturating count of accepted writes to x0
module regfile_wr_arbiter #(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic                             init_start,
  output logic                             init_busy,
  output logic [ADDRESS_WIDTH-1:0]         waddr,
  output logic [DATA_WIDTH-1:0]            wdata,
  output logic                             wena,
  output logic [$clog2(NUM_REQ)-1:0]       wr_src,
  output logic [15:0]                      x0_drops
);

  localparam int unsigned SW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t                   state;
  logic [SW-1:0]            ptr;
  logic [ADDRESS_WIDTH-1:0] cnt;

  logic                     grant_en;
  logic                     hi_found;
  logic                     lo_found;
  logic [SW-1:0]            hi_idx;
  logic [SW-1:0]            lo_idx;
  logic                     gnt_found;
  logic [SW-1:0]            gnt_idx;
  logic [ADDRESS_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0]    gnt_data;

  assign init_busy = (state == SWEEP);
  assign grant_en  = (state == IDLE) && !init_start;

  // Rotating priority as two linear scans: the lowest valid index at or
  // above ptr wins; if there is none, wrap to the lowest valid overall.
  always_comb begin
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    gnt_addr  = '0;
    gnt_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !hi_found && (i >= 32'(ptr))) begin
        hi_found = 1'b1;
        hi_idx   = SW'(i);
      end
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = SW'(i);
      end
    end
    gnt_found = lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (SW'(i) == gnt_idx) begin
        gnt_addr     = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        gnt_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = grant_en && gnt_found;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      wena     <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      wr_src   <= '0;
      x0_drops <= '0;
    end else begin
      wena <= 1'b0;
      case (state)
        IDLE: begin
          if (init_start) begin
            state <= SWEEP;
            cnt   <= ADDRESS_WIDTH'(1);
          end else if (gnt_found) begin
            ptr <= (gnt_idx == SW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            // x0 is hardwired zero: accept the request but suppress the write
            if (gnt_addr == '0) begin
              if (x0_drops != '1) begin
                x0_drops <= x0_drops + 16'd1;
              end
            end else begin
              wena   <= 1'b1;
              waddr  <= gnt_addr;
              wdata  <= gnt_data;
              wr_src <= gnt_idx;
            end
          end
        end
        SWEEP: begin
          wena   <= 1'b1;
          waddr  <= cnt;
          wdata  <= '0;
          wr_src <= '0;
          cnt    <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: a reference model predicts grants and write
// transactions into a queue, a monitor checks the registered write port
// against that queue, and a small behavioural regfile checks end contents.
module tb_regfile_wr_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = $clog2(N);
  localparam int unsigned NR = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic          init_start = 1'b0;
  logic          init_busy;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          wena;
  logic [SW-1:0] wr_src;
  logic [15:0]   x0_drops;

  regfile_wr_arbiter #(
    .NUM_REQ(N),
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .init_start(init_start),
    .init_busy(init_busy),
    .waddr(waddr),
    .wdata(wdata),
    .wena(wena),
    .wr_src(wr_src),
    .x0_drops(x0_drops)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    int            due;
  } wr_t;

  wr_t exp_q[$];
  wr_t pend[$];
  logic [DW-1:0] rf_dut[NR];
  logic [DW-1:0] rf_ref[NR];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural regfile fed by the DUT write port; x0 stays zero.
  always @(posedge clk) begin
    if (!reset && wena && waddr != '0) rf_dut[waddr] <= wdata;
  end

  // Expected writes become architectural one edge after the monitor saw them.
  always @(posedge clk) begin
    if (reset) pend.delete();
    while (pend.size() != 0) begin
      wr_t w;
      w = pend.pop_front();
      if (w.a != '0) rf_ref[w.a] = w.d;
    end
  end

  // Reference model, evaluated mid-cycle while inputs are stable.
  int            m_ptr = 0;
  int            m_k = 0;
  bit            m_sweep = 1'b0;
  int            m_drops = 0;
  int            m_g;
  int            m_j;
  logic [N-1:0]  m_er;
  logic [AW-1:0] m_a;

  always @(negedge clk) begin
    if (reset) begin
      m_ptr   = 0;
      m_k     = 0;
      m_sweep = 1'b0;
      m_drops = 0;
      exp_q.delete();
    end else begin
      m_er = '0;
      chk("init_busy", 128'(init_busy), 128'(m_sweep));
      if (m_sweep) begin
        exp_q.push_back('{a: AW'(m_k), d: '0, s: '0, due: cyc + 1});
        if (m_k == int'(NR) - 1) m_sweep = 1'b0;
        else m_k++;
      end else if (init_start) begin
        m_sweep = 1'b1;
        m_k     = 1;
      end else begin
        m_g = -1;
        for (int k = 0; k < int'(N); k++) begin
          m_j = (m_ptr + k) % int'(N);
          if (m_g < 0 && req_valid[m_j]) m_g = m_j;
        end
        if (m_g >= 0) begin
          m_a       = req_addr[m_g*AW +: AW];
          m_er[m_g] = 1'b1;
          m_ptr     = (m_g + 1) % int'(N);
          if (m_a == '0) begin
            if (m_drops < 65535) m_drops++;
          end else begin
            exp_q.push_back('{a: m_a, d: req_data[m_g*DW +: DW], s: SW'(m_g), due: cyc + 1});
          end
        end
      end
      chk("req_ready", 128'(req_ready), 128'(m_er));
    end
  end

  // Monitor: checks the registered write port just after each edge.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("x0_drops", 128'(x0_drops), 128'(m_drops));
      if (wena) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wena", 128'(wena), 128'(0));
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("write", {waddr, wdata, wr_src}, {w.a, w.d, w.s});
          chk("write_latency", 128'(cyc), 128'(w.due));
          pend.push_back(w);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        chk("missing_wena", 128'(wena), 128'(1));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_req(int i, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = reset ? '0 : (req_valid & req_ready);
    @(posedge clk);
    #2;
    req_valid  = req_valid & ~acc;
    init_start = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 8 && req_valid != '0; c++) tick();
    repeat (3) tick();
  endtask

  task automatic check_rf(string tag);
    for (int a = 0; a < int'(NR); a++) chk(tag, 128'(rf_dut[a]), 128'(rf_ref[a]));
  endtask

  int na;
  int nb;
  logic [DW-1:0] v10;
  logic [DW-1:0] v40;

  initial begin
    for (int a = 0; a < int'(NR); a++) begin
      rf_dut[a] = '0;
      rf_ref[a] = '0;
    end
    #1;
    chk("rst_wena", 128'(wena), 128'(0));
    chk("rst_waddr", 128'(waddr), 128'(0));
    chk("rst_wdata", 128'(wdata), 128'(0));
    chk("rst_x0_drops", 128'(x0_drops), 128'(0));
    chk("rst_init_busy", 128'(init_busy), 128'(0));
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    // Single requester write
    set_req(0, 6'd5, 64'h1111);
    tick();
    repeat (3) tick();
    chk("t1_reg5", 128'(rf_dut[5]), 128'(64'h1111));

    // All requesters busy: rotation 0,1,2,0,1,2
    na = 12;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!req_valid[i]) begin
          set_req(i, AW'(na), {$urandom, $urandom});
          na++;
        end
      end
      tick();
    end
    drain();

    // Write to x0 is accepted and dropped
    set_req(1, 6'd0, 64'hDEADBEEF);
    tick();
    repeat (3) tick();
    chk("t3_x0_drops", 128'(x0_drops), 128'(1));
    chk("t3_reg0", 128'(rf_dut[0]), 128'(0));

    // Sweep clears everything; a request pending across it goes next
    set_req(0, 6'd1, 64'hA1);
    set_req(1, 6'd40, 64'hA40);
    set_req(2, 6'd63, 64'hA63);
    drain();
    set_req(0, 6'd7, 64'h7777);
    init_start = 1'b1;
    tick();
    nb = 0;
    while (init_busy && nb < 100) begin
      nb++;
      if (nb == 30) init_start = 1'b1;
      tick();
    end
    chk("t4_busy_cycles", 128'(nb), 128'(63));
    repeat (4) tick();
    chk("t4_reg7", 128'(rf_dut[7]), 128'(64'h7777));
    chk("t4_reg1", 128'(rf_dut[1]), 128'(0));
    chk("t4_reg40", 128'(rf_dut[40]), 128'(0));
    chk("t4_reg63", 128'(rf_dut[63]), 128'(0));
    check_rf("t4_rf");

    // Reset in the middle of a sweep
    v10 = 64'h1010_1010;
    v40 = 64'h4040_4040;
    set_req(0, 6'd10, v10);
    set_req(1, 6'd40, v40);
    drain();
    init_start = 1'b1;
    tick();
    repeat (20) tick();
    reset     = 1'b1;
    req_valid = '0;
    #1;
    chk("t5_wena", 128'(wena), 128'(0));
    chk("t5_waddr", 128'(waddr), 128'(0));
    chk("t5_wdata", 128'(wdata), 128'(0));
    chk("t5_wr_src", 128'(wr_src), 128'(0));
    chk("t5_x0_drops", 128'(x0_drops), 128'(0));
    chk("t5_init_busy", 128'(init_busy), 128'(0));
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) tick();
    chk("t5_reg40", 128'(rf_dut[40]), 128'(v40));
    chk("t5_reg10", 128'(rf_dut[10]), 128'(0));
    check_rf("t5_rf");

    // Randomised traffic with occasional sweeps
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 7) == 0) set_req(i, 6'd0, {$urandom, $urandom});
          else set_req(i, AW'($urandom_range(1, NR - 1)), {$urandom, $urandom});
        end
      end
      if ($urandom_range(0, 99) == 0) init_start = 1'b1;
      tick();
    end
    for (int c = 0; c < 100 && init_busy; c++) tick();
    drain();
    check_rf("rand_rf");

    // Saturate the x0 drop counter
    for (int c = 0; c < 65540; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!req_valid[i]) set_req(i, 6'd0, {$urandom, $urandom});
      end
      tick();
    end
    drain();
    chk("t6_x0_sat", 128'(x0_drops), 128'(16'hFFFF));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
